// File: rtl/decode_instruction.sv
// ---------------------------------------------------------------------------
// decode_instruction
//
// Decode stage between fetch and execute. The stage is an elastic buffer with
// one main register and one skid register, each holding {pc, inst}:
//   EMPTY : nothing held, v_o = 0
//   FULL  : main holds the presented instruction, v_o = 1
//   SKID  : main and skid both hold instructions, v_o = 1, stall_o = 1
// Because stall_o comes only from the state register, there is no
// combinational path from stall_i to stall_o. The skid register absorbs the
// instruction that was already in flight when the consumer stalled.
//
// flush_i empties the stage at the next edge. This discards main, skid and any
// instruction presented in the same cycle.
//
// Decoded fields are taken combinationally from the main register.
//
// The parameter defaults match the values in the shared project parameter
// file.
//
// Ports
//   clk      : clock; all state updates happen on the rising edge
//   reset    : asynchronous, active-low reset; clears state and contents
//   v_i      : upstream valid (from fetch v_o)
//   inst_i   : upstream instruction word
//   pc_i     : upstream instruction address
//   stall_o  : backpressure to fetch (1 only in SKID)
//   flush_i  : branch-taken flush
//   v_o      : downstream valid
//   stall_i  : downstream backpressure
//   pc_o     : address of the presented instruction
//   inst_o   : raw presented instruction
//   opcode_o : inst_o[31:26]
//   rd_o     : inst_o[25:21]
//   rs_o     : inst_o[20:16]
//   rt_o     : inst_o[15:11]
//   imm_o    : inst_o[15:0] sign-extended to WORD bits
// ---------------------------------------------------------------------------
module decode_instruction #(
  parameter int WORD = 32,
  parameter int ADDR = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            v_i,
  input  logic [WORD-1:0] inst_i,
  input  logic [ADDR-1:0] pc_i,
  output logic            stall_o,
  input  logic            flush_i,
  output logic            v_o,
  input  logic            stall_i,
  output logic [ADDR-1:0] pc_o,
  output logic [WORD-1:0] inst_o,
  output logic [5:0]      opcode_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs_o,
  output logic [4:0]      rt_o,
  output logic [WORD-1:0] imm_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [ADDR-1:0] r_main_pc;
  logic [WORD-1:0] r_main_inst;
  logic [ADDR-1:0] r_skid_pc;
  logic [WORD-1:0] r_skid_inst;

  logic            w_up;
  logic            w_down;
  logic            w_load_main_in;
  logic            w_load_main_skid;
  logic            w_load_skid;

  // Handshake outputs are decoded straight from the state register.
  assign v_o     = (r_state == S_FULL) || (r_state == S_SKID);
  assign stall_o = (r_state == S_SKID);

  // A flush suppresses the upstream transfer, so the concurrent input is dropped.
  assign w_up   = v_i && !stall_o && !flush_i;
  assign w_down = v_o && !stall_i;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and load-enable logic
  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;

    if (flush_i) begin
      // Register contents are left unchanged; they are stale but unused.
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_up) begin
            w_state_next   = S_FULL;
            w_load_main_in = 1'b1;
          end
        end
        S_FULL: begin
          if (w_up && w_down) begin
            w_state_next   = S_FULL;
            w_load_main_in = 1'b1;
          end else if (w_up) begin
            w_state_next = S_SKID;
            w_load_skid  = 1'b1;
          end else if (w_down) begin
            w_state_next = S_EMPTY;
          end
        end
        S_SKID: begin
          // stall_o is high here, so w_up is always 0.
          if (w_down) begin
            w_state_next     = S_FULL;
            w_load_main_skid = 1'b1;
          end
        end
        default: begin
          w_state_next = S_EMPTY;
        end
      endcase
    end
  end

  // Main and skid storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_pc   <= '0;
      r_main_inst <= '0;
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_pc   <= pc_i;
        r_main_inst <= inst_i;
      end else if (w_load_main_skid) begin
        r_main_pc   <= r_skid_pc;
        r_main_inst <= r_skid_inst;
      end
      if (w_load_skid) begin
        r_skid_pc   <= pc_i;
        r_skid_inst <= inst_i;
      end
    end
  end

  // Presented instruction and decoded fields
  assign pc_o     = r_main_pc;
  assign inst_o   = r_main_inst;
  assign opcode_o = r_main_inst[31:26];
  assign rd_o     = r_main_inst[25:21];
  assign rs_o     = r_main_inst[20:16];
  assign rt_o     = r_main_inst[15:11];
  assign imm_o    = {{(WORD-16){r_main_inst[15]}}, r_main_inst[15:0]};

endmodule

// File: tb/tb_decode_instruction.sv
// ---------------------------------------------------------------------------
// tb_decode_instruction
//
// Self-checking bench for decode_instruction.
//
// The reference model treats the stage as a FIFO of at most two {pc, inst}
// entries:
//   - The head of the FIFO is the presented instruction.
//   - An input is accepted only when fewer than two entries are held.
//   - A flush empties the FIFO.
// A compare process checks every output against this model on every falling
// clock edge. Directed sections pin the model with literal expectations.
// A randomized section then emulates a fetch unit with random valid, stall
// and flush activity.
// ---------------------------------------------------------------------------
module tb_decode_instruction;

  logic        clk;
  logic        reset;
  logic        v_i;
  logic [31:0] inst_i;
  logic [15:0] pc_i;
  logic        stall_o;
  logic        flush_i;
  logic        v_o;
  logic        stall_i;
  logic [15:0] pc_o;
  logic [31:0] inst_o;
  logic [5:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs_o;
  logic [4:0]  rt_o;
  logic [31:0] imm_o;

  int n_checks = 0;
  int n_fail   = 0;

  decode_instruction #(.WORD(32), .ADDR(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .v_i      (v_i),
    .inst_i   (inst_i),
    .pc_i     (pc_i),
    .stall_o  (stall_o),
    .flush_i  (flush_i),
    .v_o      (v_o),
    .stall_i  (stall_i),
    .pc_o     (pc_o),
    .inst_o   (inst_o),
    .opcode_o (opcode_o),
    .rd_o     (rd_o),
    .rs_o     (rs_o),
    .rt_o     (rt_o),
    .imm_o    (imm_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] inst;
  } item_t;

  item_t q[$];
  item_t last;  // most recently presented entry; outputs hold it while empty

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      last = '0;
    end else begin
      automatic int  sz   = q.size();
      automatic bit  up   = v_i && (sz < 2) && !flush_i;
      automatic bit  down = (sz > 0) && !stall_i;
      automatic item_t it;
      it.pc   = pc_i;
      it.inst = inst_i;
      if (flush_i) begin
        q.delete();
      end else begin
        if (down) void'(q.pop_front());
        if (up) q.push_back(it);
      end
      if (q.size() > 0) last = q[0];
    end
  end

  // Compare process: checks every output on every falling edge.
  always @(negedge clk) begin
    automatic logic [31:0] mi  = last.inst;
    automatic logic [31:0] imm = (mi & 32'h8000) != 0 ? (mi & 32'hFFFF) | 32'hFFFF_0000
                                                        : (mi & 32'hFFFF);
    chk("v_o",      {63'd0, v_o},     {63'd0, q.size() > 0});
    chk("stall_o",  {63'd0, stall_o}, {63'd0, q.size() == 2});
    chk("pc_o",     {48'd0, pc_o},    {48'd0, last.pc});
    chk("inst_o",   {32'd0, inst_o},  {32'd0, mi});
    chk("opcode_o", {58'd0, opcode_o}, {32'd0, (mi >> 26)});
    chk("rd_o",     {59'd0, rd_o},    {32'd0, (mi >> 21) & 32'h1F});
    chk("rs_o",     {59'd0, rs_o},    {32'd0, (mi >> 16) & 32'h1F});
    chk("rt_o",     {59'd0, rt_o},    {32'd0, (mi >> 11) & 32'h1F});
    chk("imm_o",    {32'd0, imm_o},   {32'd0, imm});
  end

  // ---------------- stimulus ----------------
  // Apply inputs, then advance one clock edge (returns 1 time unit after it).
  task automatic drive(input logic v, input logic [15:0] pc, input logic [31:0] inst,
                       input logic st, input logic fl);
    v_i     = v;
    pc_i    = pc;
    inst_i  = inst;
    stall_i = st;
    flush_i = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] fpc;
    logic [31:0] finst;
    reset   = 1'b0;
    v_i     = 1'b0;
    pc_i    = '0;
    inst_i  = '0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    chk("rst_v_o",     {63'd0, v_o},     64'd0);
    chk("rst_stall_o", {63'd0, stall_o}, 64'd0);
    chk("rst_pc_o",    {48'd0, pc_o},    64'd0);
    chk("rst_inst_o",  {32'd0, inst_o},  64'd0);

    // Stream of three instructions with no stalls
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
      chk("stream_v_o",     {63'd0, v_o},     64'd1);
      chk("stream_pc_o",    {48'd0, pc_o},    64'(i));
      chk("stream_stall_o", {63'd0, stall_o}, 64'd0);
    end

    // Backpressure: FULL with 0x0003, then stall while 0x0004 arrives
    drive(1'b1, 16'h0003, 32'h1000_0003, 1'b0, 1'b0);
    chk("bp_pc3", {48'd0, pc_o}, 64'h3);
    drive(1'b1, 16'h0004, 32'h1000_0004, 1'b1, 1'b0);
    chk("bp_stall_o", {63'd0, stall_o}, 64'd1);
    chk("bp_hold_pc", {48'd0, pc_o},    64'h3);
    drive(1'b1, 16'h0005, 32'h1000_0005, 1'b0, 1'b0);  // blocked by stall_o
    chk("bp_rel_pc",    {48'd0, pc_o},    64'h4);
    chk("bp_rel_stall", {63'd0, stall_o}, 64'd0);

    // Flush from SKID holding 0x0005/0x0006, with 0x0007 presented
    drive(1'b1, 16'h0005, 32'h1000_0005, 1'b0, 1'b0);
    drive(1'b1, 16'h0006, 32'h1000_0006, 1'b1, 1'b0);
    chk("fl_skid_stall", {63'd0, stall_o}, 64'd1);
    chk("fl_skid_pc",    {48'd0, pc_o},    64'h5);
    drive(1'b1, 16'h0007, 32'h1000_0007, 1'b1, 1'b1);
    chk("fl_v_o",     {63'd0, v_o},     64'd0);
    chk("fl_stall_o", {63'd0, stall_o}, 64'd0);
    drive(1'b1, 16'h0012, 32'h1000_0012, 1'b0, 1'b0);
    chk("fl_after_pc", {48'd0, pc_o}, 64'h12);

    // Decode fields and sign extension
    drive(1'b1, 16'h0013, 32'hFC43_8000, 1'b0, 1'b0);
    chk("dec_opcode", {58'd0, opcode_o}, 64'h3F);
    chk("dec_rd",     {59'd0, rd_o},     64'h02);
    chk("dec_rs",     {59'd0, rs_o},     64'h03);
    chk("dec_rt",     {59'd0, rt_o},     64'h10);
    chk("dec_imm_neg", {32'd0, imm_o},   64'hFFFF_8000);
    drive(1'b1, 16'h0014, 32'h0000_7FFF, 1'b0, 1'b0);
    chk("dec_imm_pos", {32'd0, imm_o},   64'h0000_7FFF);

    // Asynchronous reset mid-cycle while in SKID
    drive(1'b1, 16'h0020, 32'h1000_0020, 1'b1, 1'b0);
    chk("ar_skid", {63'd0, stall_o}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_v_o",     {63'd0, v_o},     64'd0);
    chk("ar_stall_o", {63'd0, stall_o}, 64'd0);
    chk("ar_pc_o",    {48'd0, pc_o},    64'd0);
    chk("ar_inst_o",  {32'd0, inst_o},  64'd0);
    drive(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;

    // Randomized fetch emulation with random stalls, flushes and one reset
    fpc   = 16'h0100;
    finst = $urandom;
    for (int i = 0; i < 3000; i++) begin
      automatic logic v    = ($urandom_range(0, 3) != 0);
      automatic logic st   = ($urandom_range(0, 9) < 3);
      automatic logic fl   = ($urandom_range(0, 39) == 0);
      automatic logic took = v && !stall_o && !fl;
      drive(v, fpc, finst, st, fl);
      if (fl) begin
        fpc   = 16'($urandom);
        finst = $urandom;
      end else if (took) begin
        fpc   = fpc + 16'd1;
        finst = $urandom;
      end
      if (i == 1500) begin
        #2 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_instruction.md
DECODE_INSTRUCTION -- requirements
Module: decode_instruction

Interface
REQ-001 Parameter WORD, default 32, instruction and data width; value taken from include/params.v.
REQ-002 Parameter ADDR, default 16, instruction address width; value taken from include/params.v.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 v_i  input  1  upstream valid, driven by fetch_instruction v_o.
REQ-006 inst_i  input  WORD  upstream instruction, driven by fetch inst_o.
REQ-007 pc_i  input  ADDR  upstream instruction address, driven by fetch pc_o.
REQ-008 stall_o  output  1  backpressure to fetch stall_i; 1 = do not present new instruction.
REQ-009 flush_i  input  1  branch-taken flush; same cycle fetch sees branch=1.
REQ-010 v_o  output  1  downstream valid.
REQ-011 stall_i  input  1  downstream backpressure.
REQ-012 pc_o  output  ADDR  address of the presented instruction.
REQ-013 inst_o  output  WORD  raw presented instruction.
REQ-014 opcode_o  output  6  inst_o[31:26].
REQ-015 rd_o, rs_o, rt_o  output  5 each  inst_o[25:21], [20:16], [15:11].
REQ-016 imm_o  output  WORD  inst_o[15:0] sign-extended to WORD.

Function
REQ-017 Upstream transfer SHALL occur on a rising edge where v_i=1, stall_o=0, flush_i=0.
REQ-018 Downstream transfer SHALL occur on a rising edge where v_o=1, stall_i=0.
REQ-019 Storage SHALL be a main register (drives outputs) plus one skid register; each holds {pc, inst}.
REQ-020 States: EMPTY (none valid), FULL (main valid), SKID (main and skid valid).
REQ-021 v_o SHALL be 1 in FULL and SKID, 0 in EMPTY; stall_o SHALL be 1 only in SKID, registered (no combinational path from stall_i).
REQ-022 EMPTY: upstream transfer -> FULL, main loads input; else stay.
REQ-023 FULL: in and out -> FULL, main loads input; in only -> SKID, skid loads input; out only -> EMPTY; neither -> stay.
REQ-024 SKID: out -> FULL, main loads skid contents; else stay; no upstream transfer possible (stall_o=1).
REQ-025 Latency: instruction accepted at edge N appears on outputs after edge N when not stalled (one cycle).
REQ-026 Order SHALL be preserved; no instruction dropped or duplicated outside flush.
REQ-027 flush_i=1 at an edge SHALL force EMPTY, discard main, skid and the concurrent input, regardless of stall_i; v_o=0 and stall_o=0 after that edge.
REQ-028 Decoded fields (REQ-014..016) SHALL be combinational from main register; pc_o/inst_o from main register.
REQ-029 When v_o=0, data outputs hold last value (don't-care to consumers), except after reset.
REQ-030 Sign extension: imm_o[WORD-1:16] = inst_o[15]; 0x8000 -> 0xFFFF8000, 0x7FFF -> 0x00007FFF.

Reset
REQ-031 reset=0 SHALL immediately, independent of clk, force EMPTY, v_o=0, stall_o=0, main and skid contents 0 (so pc_o, inst_o, all fields 0).
REQ-032 Reset asserted mid-transfer or in SKID SHALL discard all held instructions; first edge after reset=1 behaves as EMPTY.

Verification
REQ-033 Stream: reset release, v_i=1, pc_i 0x0000,0x0001,0x0002, stall_i=0 -> v_o=1 one cycle later, pc_o 0x0000,0x0001,0x0002 in order, stall_o stays 0.
REQ-034 Backpressure: FULL with pc 0x0003, stall_i=1, v_i=1 pc_i 0x0004 -> SKID, stall_o=1 next cycle, pc_o held 0x0003; release stall_i -> pc_o 0x0004 next, stall_o=0, no loss.
REQ-035 Flush: SKID holding 0x0005/0x0006, flush_i=1 with v_i=1 pc_i 0x0007 -> v_o=0, stall_o=0 next; then pc_i 0x0012 accepted -> pc_o 0x0012.
REQ-036 Decode: inst_i 0xFC43_8000 -> opcode_o 0x3F, rd_o 0x02, rs_o 0x03, rt_o 0x10, imm_o 0xFFFF8000.
REQ-037 Async reset: assert reset=0 mid-cycle in SKID -> v_o, stall_o, pc_o, inst_o go 0 before next edge.
REQ-038 Loop with fetch_instruction and DP_mem32x64k, random stall_i -> downstream pc sequence equals fetch pc sequence without gaps or repeats.
